// File: rtl/udp_pkg.sv
// Shared constants, header layout and FSM encoding for the UDP frame packer.
package udp_pkg;

  localparam logic [15:0] UDP_MAGIC = 16'hDA7A;

  // Header word bit offsets (64-bit word, MSB first on the wire)
  localparam int HDR_MAGIC_LSB  = 48;
  localparam int HDR_SEQ_LSB    = 32;
  localparam int HDR_TS_LSB     = 16;
  localparam int HDR_NBEATS_LSB = 8;

  localparam int WORDS_PER_BEAT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_e;

  function automatic logic [63:0] make_header(input logic [15:0] seq,
                                              input logic [15:0] ts,
                                              input logic [7:0]  n_beats);
    logic [63:0] h;
    h = '0;
    h[HDR_MAGIC_LSB  +: 16] = UDP_MAGIC;
    h[HDR_SEQ_LSB    +: 16] = seq;
    h[HDR_TS_LSB     +: 16] = ts;
    h[HDR_NBEATS_LSB +: 8]  = n_beats;
    return h;
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// Synchronous FIFO with registered count/full/empty; read data is the head entry (fall-through).
// Writes while full are ignored; full comes from the registered count, so a same-cycle pop does not free a slot.
module beat_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  // Explicit wrap keeps non-power-of-two and single-entry depths correct
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/udp_frame_packer.sv
// Packs 256-bit DRAM read beats into header-prefixed 64-bit packets; header is valid one cycle after the filling beat lands.
// Input is never stalled (overflow beats are dropped and flagged); output holds word/sop/eop until out_ready.
module udp_frame_packer
  import udp_pkg::*;
#(
  parameter int BEATS_PER_PKT = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] in_data,
  input  logic         in_valid,
  input  logic         in_trigger,
  input  logic [15:0]  in_trigger_ts,
  output logic [63:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sop,
  output logic         out_eop,
  output logic         overflow,
  output logic [15:0]  seq_num
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BPP_C     = CW'(BEATS_PER_PKT);
  localparam logic [IW-1:0] TMO_C     = IW'(TIMEOUT);
  localparam logic [1:0]    LAST_WORD = 2'(WORDS_PER_BEAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    word_q, word_d;
  logic [7:0]    beat_q, beat_d;
  logic [7:0]    nbeats_q, nbeats_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   ts_q, ts_d;
  logic [15:0]   hdr_ts_q, hdr_ts_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ovf_q, ovf_d;

  logic [255:0]  fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          pop;

  logic          last_word;
  logic          eop_hs;
  logic [CW-1:0] avail;
  logic          pkt_ready;
  logic          timeout_hit;
  logic          enter_hdr;

  beat_fifo #(
    .WIDTH (256),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_valid),
    .wr_data_i (in_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign last_word = (state_q == PAY) && (word_q == LAST_WORD) && (beat_q == nbeats_q - 8'd1);
  assign eop_hs    = last_word && out_ready;
  assign pop       = (state_q == PAY) && out_ready && (word_q == LAST_WORD);

  // In PAY the head beat is still counted but leaves on the eop edge, so it is excluded
  assign avail       = (state_q == PAY) ? fifo_count - CW'(1) : fifo_count;
  assign pkt_ready   = (avail >= BPP_C);
  assign timeout_hit = !fifo_empty && (idle_q == TMO_C);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pkt_ready || timeout_hit) state_d = HDR;
      HDR:     if (out_ready) state_d = PAY;
      PAY:     if (eop_hs) state_d = pkt_ready ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q != IDLE);
    out_sop   = (state_q == HDR);
    out_eop   = last_word;
    out_data  = '0;
    if (state_q == HDR) begin
      out_data = make_header(seq_q, hdr_ts_q, nbeats_q);
    end else if (state_q == PAY) begin
      unique case (word_q)
        2'd0:    out_data = fifo_rd_data[63:0];
        2'd1:    out_data = fifo_rd_data[127:64];
        2'd2:    out_data = fifo_rd_data[191:128];
        default: out_data = fifo_rd_data[255:192];
      endcase
    end
  end

  assign enter_hdr = (state_q != HDR) && (state_d == HDR);

  // Header fields are frozen on HDR entry so the held word cannot change under backpressure
  always_comb begin
    nbeats_d = nbeats_q;
    hdr_ts_d = hdr_ts_q;
    if (enter_hdr) begin
      nbeats_d = pkt_ready ? 8'(BEATS_PER_PKT) : 8'(avail);
      hdr_ts_d = ts_q;
    end

    word_d = word_q;
    beat_d = beat_q;
    if (state_q == HDR) begin
      word_d = '0;
      beat_d = '0;
    end else if (state_q == PAY && out_ready) begin
      word_d = word_q + 2'd1;
      if (word_q == LAST_WORD) beat_d = beat_q + 8'd1;
    end

    seq_d = eop_hs ? seq_q + 16'd1 : seq_q;
    ts_d  = in_trigger ? in_trigger_ts : ts_q;
    ovf_d = ovf_q | (in_valid && fifo_full);

    idle_d = idle_q;
    if (in_valid || fifo_empty || state_q != IDLE) idle_d = '0;
    else if (idle_q != TMO_C)                      idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q   <= '0;
      beat_q   <= '0;
      nbeats_q <= '0;
      seq_q    <= '0;
      ts_q     <= '0;
      hdr_ts_q <= '0;
      idle_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      word_q   <= word_d;
      beat_q   <= beat_d;
      nbeats_q <= nbeats_d;
      seq_q    <= seq_d;
      ts_q     <= ts_d;
      hdr_ts_q <= hdr_ts_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
    end
  end

  assign overflow = ovf_q;
  assign seq_num  = seq_q;

endmodule

// File: tb/tb_udp_frame_packer.sv
// Scenario bench for udp_frame_packer: random beats and ready patterns checked against packets rebuilt from the sent beats.
module tb_udp_frame_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_trigger = 1'b0;
  logic [15:0]  in_trigger_ts = '0;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sop;
  logic         out_eop;
  logic         overflow;
  logic [15:0]  seq_num;

  always #5 clk = ~clk;

  udp_frame_packer #(
    .BEATS_PER_PKT (8),
    .FIFO_DEPTH    (16),
    .TIMEOUT       (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_trigger    (in_trigger),
    .in_trigger_ts (in_trigger_ts),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .overflow      (overflow),
    .seq_num       (seq_num)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stab_err = 0;

  logic [63:0]  rx_dat[$];
  logic         rx_sop[$];
  logic         rx_eop[$];
  int           rx_cyc[$];
  logic [63:0]  exp_q[$];
  logic [255:0] beats[$];
  logic [15:0]  ts_last;

  logic         hold = 1'b0;
  logic [63:0]  hold_dat;
  logic         hold_sop, hold_eop;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference model: header is magic, seq, ts, beat count, zero byte; then each beat low 64 bits first
  task automatic exp_pkt(input logic [15:0] seq, input logic [15:0] ts, input int first, input int n);
    logic [255:0] bb;
    logic [7:0]   n8;
    n8 = 8'(n);
    exp_q.push_back({16'hDA7A, seq, ts, n8, 8'h00});
    for (int b = 0; b < n; b++) begin
      bb = beats[first + b];
      for (int k = 0; k < 4; k++) exp_q.push_back(bb[64*k +: 64]);
    end
  endtask

  task automatic clear_all();
    rx_dat.delete(); rx_sop.delete(); rx_eop.delete(); rx_cyc.delete();
    exp_q.delete(); beats.delete();
    stab_err = 0;
  endtask

  // One clock: observe the word on offer, log it if accepted, then drive the next inputs
  task automatic cycle(input logic v, input logic [255:0] d, input logic rdy);
    if (hold) begin
      if (!out_valid || out_data !== hold_dat || out_sop !== hold_sop || out_eop !== hold_eop)
        stab_err++;
    end
    if (out_valid && rdy) begin
      rx_dat.push_back(out_data);
      rx_sop.push_back(out_sop);
      rx_eop.push_back(out_eop);
      rx_cyc.push_back(cyc);
    end
    hold     = out_valid && !rdy;
    hold_dat = out_data;
    hold_sop = out_sop;
    hold_eop = out_eop;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_trigger(input logic [15:0] ts);
    in_trigger    = 1'b1;
    in_trigger_ts = ts;
    cycle(1'b0, '0, 1'b1);
    in_trigger = 1'b0;
    ts_last    = ts;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %0b want 0", out_sop); end
    checks++; if (out_eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got %0b want 0", out_eop); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (seq_num !== 16'h0) begin errors++; $display("FAIL reset_seq: got %h want 0", seq_num); end
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_full_packet();
    int last;
    clear_all();
    pulse_trigger(16'h1234);
    for (int i = 0; i < 8; i++) begin
      beats.push_back(rnd256());
      last = cyc;
      cycle(1'b1, beats[i], 1'b1);
    end
    repeat (40) cycle(1'b0, '0, 1'b1);
    exp_pkt(16'h0000, 16'h1234, 0, 8);
    checks++; if (rx_dat.size() != 33) begin errors++; $display("FAIL full_count: got %0d want 33", rx_dat.size()); end
    checks++;
    if (rx_dat.size() == 0 || rx_dat[0] !== 64'hDA7A_0000_1234_0800) begin
      errors++; $display("FAIL full_header: got %h want da7a000012340800", (rx_dat.size() > 0) ? rx_dat[0] : 64'h0);
    end
    checks++;
    if (rx_cyc.size() == 0 || rx_cyc[0] != last + 2) begin
      errors++; $display("FAIL full_latency: got cycle %0d want %0d", (rx_cyc.size() > 0) ? rx_cyc[0] : -1, last + 2);
    end
    checks++;
    if (rx_cyc.size() < 33 || rx_cyc[32] - rx_cyc[0] != 32) begin
      errors++; $display("FAIL full_throughput: packet span not 32 cycles (words %0d)", rx_cyc.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_dat.size(); i++) begin
      checks++;
      if (rx_dat[i] !== exp_q[i] || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == 32)) begin
        errors++;
        $display("FAIL full_word%0d: got %h sop=%0b eop=%0b want %h sop=%0b eop=%0b",
                 i, rx_dat[i], rx_sop[i], rx_eop[i], exp_q[i], (i == 0), (i == 32));
      end
    end
    checks++; if (seq_num !== 16'd1) begin errors++; $display("FAIL full_seq: got %0d want 1", seq_num); end
  endtask

  task automatic test_timeout();
    int last;
    clear_all();
    pulse_trigger(16'($urandom()));
    for (int i = 0; i < 3; i++) begin
      beats.push_back(rnd256());
      last = cyc;
      cycle(1'b1, beats[i], 1'b1);
    end
    repeat (300) cycle(1'b0, '0, 1'b1);
    exp_pkt(16'd1, ts_last, 0, 3);
    checks++; if (rx_dat.size() != 13) begin errors++; $display("FAIL tmo_count: got %0d want 13", rx_dat.size()); end
    checks++;
    if (rx_cyc.size() == 0 || rx_cyc[0] != last + 257) begin
      errors++; $display("FAIL tmo_latency: got cycle %0d want %0d", (rx_cyc.size() > 0) ? rx_cyc[0] : -1, last + 257);
    end
    for (int i = 0; i < exp_q.size() && i < rx_dat.size(); i++) begin
      checks++;
      if (rx_dat[i] !== exp_q[i] || rx_eop[i] !== (i == 12)) begin
        errors++; $display("FAIL tmo_word%0d: got %h eop=%0b want %h eop=%0b", i, rx_dat[i], rx_eop[i], exp_q[i], (i == 12));
      end
    end
    checks++; if (seq_num !== 16'd2) begin errors++; $display("FAIL tmo_seq: got %0d want 2", seq_num); end
  endtask

  task automatic test_overflow();
    clear_all();
    for (int i = 0; i < 20; i++) begin
      beats.push_back(rnd256());
      cycle(1'b1, beats[i], 1'b0);
      if (i == 15) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b want 0 at 16 beats", overflow); end
      end
    end
    cycle(1'b0, '0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    checks++; if (!(out_valid && out_sop)) begin errors++; $display("FAIL ovf_hdr_wait: valid=%0b sop=%0b want 1 1", out_valid, out_sop); end
    repeat (100) cycle(1'b0, '0, 1'b1);
    exp_pkt(16'd2, ts_last, 0, 8);
    exp_pkt(16'd3, ts_last, 8, 8);
    checks++; if (rx_dat.size() != 66) begin errors++; $display("FAIL ovf_count: got %0d want 66", rx_dat.size()); end
    checks++;
    if (rx_cyc.size() < 66 || rx_cyc[65] - rx_cyc[0] != 65) begin
      errors++; $display("FAIL ovf_back_to_back: two packets not contiguous (words %0d)", rx_cyc.size());
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL ovf_stable: got %0d hold violations want 0", stab_err); end
    for (int i = 0; i < exp_q.size() && i < rx_dat.size(); i++) begin
      checks++;
      if (rx_dat[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d: got %h want %h", i, rx_dat[i], exp_q[i]); end
    end
    checks++; if (seq_num !== 16'd4) begin errors++; $display("FAIL ovf_seq: got %0d want 4", seq_num); end
  endtask

  task automatic test_random_ready();
    clear_all();
    pulse_trigger(16'($urandom()));
    for (int i = 0; i < 16; i++) begin
      beats.push_back(rnd256());
      cycle(1'b1, beats[i], 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 800 && rx_dat.size() < 66; k++) cycle(1'b0, '0, 1'($urandom_range(0, 1)));
    exp_pkt(16'd4, ts_last, 0, 8);
    exp_pkt(16'd5, ts_last, 8, 8);
    checks++; if (rx_dat.size() != 66) begin errors++; $display("FAIL rnd_count: got %0d want 66", rx_dat.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rnd_stable: got %0d hold violations want 0", stab_err); end
    for (int i = 0; i < exp_q.size() && i < rx_dat.size(); i++) begin
      checks++;
      if (rx_dat[i] !== exp_q[i] || rx_sop[i] !== (i == 0 || i == 33)) begin
        errors++; $display("FAIL rnd_word%0d: got %h sop=%0b want %h", i, rx_dat[i], rx_sop[i], exp_q[i]);
      end
    end
    checks++; if (seq_num !== 16'd6) begin errors++; $display("FAIL rnd_seq: got %0d want 6", seq_num); end
  endtask

  task automatic test_seq_wrap();
    clear_all();
    force dut.seq_q = 16'hFFFF;
    cycle(1'b0, '0, 1'b1);
    release dut.seq_q;
    cycle(1'b0, '0, 1'b1);
    checks++; if (seq_num !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", seq_num); end
    for (int i = 0; i < 16; i++) begin
      beats.push_back(rnd256());
      cycle(1'b1, beats[i], 1'b1);
    end
    repeat (80) cycle(1'b0, '0, 1'b1);
    exp_pkt(16'hFFFF, ts_last, 0, 8);
    exp_pkt(16'h0000, ts_last, 8, 8);
    checks++; if (rx_dat.size() != 66) begin errors++; $display("FAIL wrap_count: got %0d want 66", rx_dat.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_dat.size(); i++) begin
      checks++;
      if (rx_dat[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", i, rx_dat[i], exp_q[i]); end
    end
    checks++; if (seq_num !== 16'd1) begin errors++; $display("FAIL wrap_seq: got %0d want 1", seq_num); end
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int i = 0; i < 8; i++) begin
      beats.push_back(rnd256());
      cycle(1'b1, beats[i], 1'b1);
    end
    for (int k = 0; k < 100 && rx_dat.size() < 10; k++) cycle(1'b0, '0, 1'b1);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    checks++; if (seq_num !== 16'd0) begin errors++; $display("FAIL rstmid_seq: got %0d want 0", seq_num); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %0b want 0", overflow); end
    clear_all();
    repeat (300) cycle(1'b0, '0, 1'b1);
    checks++; if (rx_dat.size() != 0) begin errors++; $display("FAIL rstmid_fifo_empty: got %0d stray words want 0", rx_dat.size()); end
    clear_all();
    for (int i = 0; i < 8; i++) begin
      beats.push_back(rnd256());
      cycle(1'b1, beats[i], 1'b1);
    end
    repeat (40) cycle(1'b0, '0, 1'b1);
    exp_pkt(16'd0, 16'd0, 0, 8);
    checks++; if (rx_dat.size() != 33) begin errors++; $display("FAIL rstmid_count: got %0d want 33", rx_dat.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_dat.size(); i++) begin
      checks++;
      if (rx_dat[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h want %h", i, rx_dat[i], exp_q[i]); end
    end
    checks++; if (seq_num !== 16'd1) begin errors++; $display("FAIL rstmid_seq_after: got %0d want 1", seq_num); end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_timeout();
    test_overflow();
    test_random_ready();
    test_seq_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
